// File: rtl/fc_layer4.sv
// Fully-connected classifier after the layer-3 max-pool: buffers one image of
// pooled 16-channel beats, then scores each class against an external weight ROM.
//
// state | meaning
// IDLE  | waiting for conv_start
// FILL  | capturing pooled beats into the buffer
// MAC   | issuing one buffer/ROM read per position for class c
// DRAIN | two cycles for the read/accumulate pipeline to empty
// NEXT  | score strobe visible; advance to the next class
// DONE  | fc_4_complete visible; class_id updated
module fc_layer4 #(
  parameter int NUM_POS     = 64,
  parameter int NUM_CLASSES = 6,
  parameter int ACC_W       = 32,
  localparam int AW = $clog2(NUM_CLASSES * NUM_POS),
  localparam int PW = $clog2(NUM_POS + 1),
  localparam int IW = $clog2(NUM_POS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    conv_start,
  input  logic [127:0]            d_in,
  input  logic                    relu_3_ready,
  input  logic                    relu_3_complete,
  output logic [AW-1:0]           w_addr,
  input  logic [127:0]            w_data,
  output logic signed [ACC_W-1:0] score,
  output logic [2:0]              score_idx,
  output logic                    score_valid,
  output logic [2:0]              class_id,
  output logic                    fc_4_complete,
  output logic                    overflow
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FILL, ST_MAC, ST_DRAIN, ST_NEXT, ST_DONE
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state, state_nx;

  logic [PW-1:0]           pos_cnt, n_pos, n_pos_nx;
  logic [IW-1:0]           p;
  logic [2:0]              c;
  logic                    dcnt;
  logic [127:0]            buf_mem [NUM_POS];
  logic [127:0]            rd_q;
  logic                    rd_vld;
  logic signed [ACC_W-1:0] acc, best;
  logic [2:0]              best_idx;

  logic                    buf_we, drop, fill_done, mac_issue, mac_last, class_last;
  logic [AW-1:0]           addr_inc, addr_next_class;

  logic signed [16:0]      f_ext, w_ext, prod;
  logic signed [20:0]      dot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (conv_start) begin
      state_nx = ST_FILL;
    end else begin
      case (state)
        ST_IDLE:  state_nx = ST_IDLE;
        ST_FILL:  if (relu_3_complete) state_nx = (n_pos_nx == '0) ? ST_DONE : ST_MAC;
        ST_MAC:   if (mac_last) state_nx = ST_DRAIN;
        ST_DRAIN: if (dcnt) state_nx = ST_NEXT;
        ST_NEXT:  state_nx = class_last ? ST_DONE : ST_MAC;
        ST_DONE:  state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    buf_we          = (state == ST_FILL) && !conv_start && relu_3_ready && (pos_cnt < PW'(NUM_POS));
    drop            = (state == ST_FILL) && !conv_start && relu_3_ready && (pos_cnt >= PW'(NUM_POS));
    n_pos_nx        = pos_cnt + PW'(buf_we);
    fill_done       = (state == ST_FILL) && !conv_start && relu_3_complete;
    mac_issue       = (state == ST_MAC) && !conv_start;
    mac_last        = (PW'(p) == n_pos - PW'(1));
    class_last      = (c == 3'(NUM_CLASSES - 1));
    addr_inc        = AW'(c) * AW'(NUM_POS) + AW'(p) + AW'(1);
    addr_next_class = (AW'(c) + AW'(1)) * AW'(NUM_POS);
  end

  // Feature is zero-extended to 9 bits so the product stays signed
  always_comb begin
    dot   = '0;
    f_ext = '0;
    w_ext = '0;
    prod  = '0;
    for (int k = 0; k < 16; k++) begin
      f_ext = 17'($signed({1'b0, rd_q[8*k +: 8]}));
      w_ext = 17'($signed(w_data[8*k +: 8]));
      prod  = f_ext * w_ext;
      dot   = dot + 21'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[pos_cnt[IW-1:0]] <= d_in;
    rd_q <= buf_mem[p];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_cnt       <= '0;
      n_pos         <= '0;
      overflow      <= 1'b0;
      p             <= '0;
      c             <= '0;
      dcnt          <= 1'b0;
      rd_vld        <= 1'b0;
      acc           <= '0;
      best          <= '0;
      best_idx      <= '0;
      w_addr        <= '0;
      score         <= '0;
      score_idx     <= '0;
      score_valid   <= 1'b0;
      class_id      <= '0;
      fc_4_complete <= 1'b0;
    end else begin
      if (conv_start) begin
        pos_cnt  <= '0;
        overflow <= 1'b0;
      end else begin
        if (buf_we) pos_cnt <= pos_cnt + PW'(1);
        if (drop)   overflow <= 1'b1;
      end
      if (fill_done) n_pos <= n_pos_nx;

      rd_vld <= mac_issue;
      dcnt   <= (state == ST_DRAIN) && !dcnt && !conv_start;
      if (rd_vld) acc <= acc + ACC_W'(dot);

      if (fill_done && state_nx == ST_MAC) begin
        c        <= '0;
        p        <= '0;
        acc      <= '0;
        best     <= ACC_MIN;
        best_idx <= '0;
        w_addr   <= '0;
      end
      if (mac_issue && !mac_last) begin
        p      <= p + IW'(1);
        w_addr <= addr_inc;
      end
      if (state == ST_NEXT && !conv_start) begin
        c   <= c + 3'd1;
        p   <= '0;
        acc <= '0;
        if (!class_last) w_addr <= addr_next_class;
      end

      score_valid <= (state_nx == ST_NEXT);
      if (state_nx == ST_NEXT) begin
        score     <= acc;
        score_idx <= c;
        // strict compare: on ties the earlier (lower) class wins
        if (acc > best) begin
          best     <= acc;
          best_idx <= c;
        end
      end

      fc_4_complete <= (state_nx == ST_DONE);
      if (state_nx == ST_DONE) class_id <= (state == ST_FILL) ? 3'd0 : best_idx;
    end
  end

endmodule

// File: tb/tb_fc_layer4.sv
// Directed bench for fc_layer4: ROM model with 1-cycle latency, strobe monitor,
// hand-computed scores, arg-max, latency, overflow, abort and reset checks.
module tb_fc_layer4;

  localparam int AW = 9;

  logic               clk;
  logic               rst;
  logic               conv_start;
  logic [127:0]       d_in;
  logic               relu_3_ready;
  logic               relu_3_complete;
  logic [AW-1:0]      w_addr;
  logic [127:0]       w_data;
  logic signed [31:0] score;
  logic [2:0]         score_idx;
  logic               score_valid;
  logic [2:0]         class_id;
  logic               fc_4_complete;
  logic               overflow;

  fc_layer4 dut (
    .clk             (clk),
    .rst             (rst),
    .conv_start      (conv_start),
    .d_in            (d_in),
    .relu_3_ready    (relu_3_ready),
    .relu_3_complete (relu_3_complete),
    .w_addr          (w_addr),
    .w_data          (w_data),
    .score           (score),
    .score_idx       (score_idx),
    .score_valid     (score_valid),
    .class_id        (class_id),
    .fc_4_complete   (fc_4_complete),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] rom [384];
  always @(posedge clk) w_data <= rom[w_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;
  int t_cmp = -1000;
  int sv_cnt, sv_first, fc_cnt, fc_cyc;
  int sc [6];
  int wlog [64];

  always @(negedge clk) begin
    if (score_valid) begin
      if (sv_cnt == 0) sv_first = cyc;
      if (score_idx < 3'd6) sc[score_idx] = score;
      sv_cnt++;
    end
    if (fc_4_complete) begin
      fc_cnt++;
      fc_cyc = cyc;
    end
    if (cyc - t_cmp >= 0 && cyc - t_cmp < 64) wlog[cyc - t_cmp] = int'(w_addr);
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 384; i++) rom[i] = '0;
  endtask

  task automatic set_class(input int cl, input logic [7:0] w);
    for (int i = 0; i < 64; i++) rom[cl*64 + i] = {16{w}};
  endtask

  task automatic set_lane0(input int cl, input logic [7:0] w);
    for (int i = 0; i < 64; i++) rom[cl*64 + i] = {120'b0, w};
  endtask

  task automatic start_image();
    conv_start = 1'b1;
    t_cmp    = -1000;
    sv_cnt   = 0;
    sv_first = -1;
    fc_cnt   = 0;
    fc_cyc   = -1;
    for (int i = 0; i < 6; i++) sc[i] = -12345;
    @(posedge clk); #1;
    conv_start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] f, input bit same);
    for (int i = 0; i < n; i++) begin
      relu_3_ready = 1'b1;
      d_in = {16{f}};
      if (same && i == n - 1) begin
        relu_3_complete = 1'b1;
        t_cmp = cyc;
      end
      @(posedge clk); #1;
    end
    relu_3_ready = 1'b0;
    d_in = '0;
    if (!(same && n > 0)) begin
      relu_3_complete = 1'b1;
      t_cmp = cyc;
      @(posedge clk); #1;
    end
    relu_3_complete = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && fc_cnt == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("done_cnt", fc_cnt, 1);
  endtask

  task automatic check_image(input string tag, input int e [6], input int cls, input int lat);
    chk({tag, "_nsv"}, sv_cnt, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("%s_score%0d", tag, i), sc[i], e[i]);
    chk({tag, "_class"}, class_id, cls);
    chk({tag, "_fc_lat"}, fc_cyc - t_cmp, lat);
    chk({tag, "_sv_lat"}, sv_first - t_cmp, (lat - 1) / 6);
  endtask

  initial begin
    rst = 1'b1;
    conv_start = 1'b0;
    relu_3_ready = 1'b0;
    relu_3_complete = 1'b0;
    d_in = '0;
    clear_rom();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_waddr", w_addr, 0);
    chk("rst_score", score, 0);
    chk("rst_sv", score_valid, 0);
    chk("rst_class", class_id, 0);
    chk("rst_fc", fc_4_complete, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ones against class-2 unit weights
    clear_rom();
    set_class(2, 8'd1);
    start_image();
    feed(64, 8'd1, 1'b0);
    wait_done(600);
    check_image("img1", '{0, 0, 1024, 0, 0, 0}, 2, 403);
    chk("img1_ovf", overflow, 0);

    // full-scale feature against extreme lane-0 weights
    clear_rom();
    set_lane0(0, 8'h80);
    set_lane0(1, 8'h7f);
    start_image();
    feed(64, 8'hff, 1'b0);
    wait_done(600);
    check_image("img2", '{-2088960, 2072640, 0, 0, 0, 0}, 1, 403);

    // all-zero weights: six-way tie resolves to class 0
    clear_rom();
    start_image();
    feed(64, 8'hff, 1'b0);
    wait_done(600);
    check_image("img3", '{0, 0, 0, 0, 0, 0}, 0, 403);

    // 3 beats, complete with the last beat
    clear_rom();
    for (int cl = 0; cl < 6; cl++) set_class(cl, 8'(cl));
    start_image();
    feed(3, 8'd3, 1'b1);
    wait_done(200);
    check_image("img4", '{0, 144, 288, 432, 576, 720}, 5, 37);
    chk("waddr_t1", wlog[1], 0);
    chk("waddr_t2", wlog[2], 1);
    chk("waddr_t3", wlog[3], 2);
    chk("waddr_hold", wlog[5], 2);
    chk("waddr_t7", wlog[7], 64);
    chk("waddr_t8", wlog[8], 65);
    chk("waddr_t9", wlog[9], 66);

    // 65 beats: the extra one is dropped
    clear_rom();
    set_class(0, 8'h80);
    set_class(4, 8'd1);
    start_image();
    feed(65, 8'hff, 1'b0);
    wait_done(600);
    check_image("img5", '{-33423360, 0, 0, 0, 261120, 0}, 4, 403);
    chk("img5_ovf", overflow, 1);

    // abort mid-MAC, then a fresh image
    start_image();
    feed(65, 8'd1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_ovf_pre", overflow, 1);
    start_image();
    chk("abort_ovf_post", overflow, 0);
    set_class(3, 8'd2);
    repeat (150) @(posedge clk);
    #1;
    chk("abort_nsv", sv_cnt, 0);
    chk("abort_nfc", fc_cnt, 0);
    chk("abort_class", class_id, 4);
    feed(10, 8'd2, 1'b0);
    wait_done(200);
    check_image("img6", '{-40960, 0, 0, 640, 320, 0}, 3, 79);

    // asynchronous reset during the first DRAIN cycle
    clear_rom();
    for (int cl = 0; cl < 6; cl++) set_class(cl, 8'(cl));
    start_image();
    feed(3, 8'd3, 1'b1);
    repeat (t_cmp + 4 - cyc) @(posedge clk);
    #1;
    chk("drain_waddr", w_addr, 2);
    rst = 1'b1;
    #1;
    chk("arst_waddr", w_addr, 0);
    chk("arst_score", score, 0);
    chk("arst_idx", score_idx, 0);
    chk("arst_sv", score_valid, 0);
    chk("arst_class", class_id, 0);
    chk("arst_fc", fc_4_complete, 0);
    chk("arst_ovf", overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("arst_nsv", sv_cnt, 0);
    chk("arst_nfc", fc_cnt, 0);

    start_image();
    feed(3, 8'd3, 1'b1);
    wait_done(200);
    check_image("img8", '{0, 144, 288, 432, 576, 720}, 5, 37);

    // empty image: complete with no beats
    start_image();
    feed(0, 8'd0, 1'b0);
    wait_done(50);
    chk("empty_nsv", sv_cnt, 0);
    chk("empty_class", class_id, 0);
    chk("empty_lat", fc_cyc - t_cmp, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
